// File: rtl/systolic_pkg.sv
// systolic_pkg: lane count, index widths, FSM states and saturation limits shared by the result path.
package systolic_pkg;
  localparam int LANES = 4;
  localparam int IDX_W = 5;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, EMIT} state_e;
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers; push is accepted when full only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/result_drain.sv
// result_drain: requantises four accumulator lanes into a FIFO and drains the set lanes as a ready/valid stream.
// Define RESULT_DRAIN_RELU_EN to clamp negative shifted values to zero before saturation.
module result_drain
  import systolic_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int DEPTH = 8,
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [LANES-1:0]        valid_in,
  input  logic [SEL_W-1:0]        acc_sel_tile1,
  input  logic [SEL_W-1:0]        acc_sel_tile2,
  output logic signed [W-1:0]     y_data,
  output logic [IDX_W-1:0]        y_idx,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    y_last,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  input  logic                    clr_ovf
);
  localparam int LW = $clog2(LANES);
  localparam int EW = LANES + LANES * W + 2 * SEL_W;
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [LANES-1:0] sent_q, sent_d, mask, rem;
  logic ovf_q, ovf_d, push, pop, fire;
  logic [LW-1:0] lane;
  logic [SEL_W-1:0] sel1, sel2;
  logic [EW-1:0] din, head;
  logic [CW-1:0] count;

  function automatic logic signed [W-1:0] requant(input logic signed [ACC_W-1:0] a);
    int s;
`ifdef RESULT_DRAIN_RELU_EN
    s = (int'(a >>> SHIFT) < 0) ? 0 : int'(a >>> SHIFT);
`else
    s = int'(a >>> SHIFT);
`endif
    return (s > sat_max(W)) ? W'(sat_max(W)) : (s < sat_min(W)) ? W'(sat_min(W)) : W'(s);
  endfunction

  // Entry layout, LSB first: lane mask, four requantised lanes, sel1, sel2.
  assign din = {acc_sel_tile2, acc_sel_tile1, requant(acc_in_3), requant(acc_in_2),
                requant(acc_in_1), requant(acc_in_0), valid_in};

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign mask = head[LANES-1:0];
  assign sel1 = head[EW-2*SEL_W +: SEL_W];
  assign sel2 = head[EW-SEL_W +: SEL_W];
  assign rem = mask & ~sent_q;
  assign lane = rem[0] ? LW'(0) : rem[1] ? LW'(1) : rem[2] ? LW'(2) : LW'(3);
  assign y_valid = state_q == EMIT;
  assign y_last = y_valid & ((rem & (rem - LANES'(1))) == '0);
  assign y_data = y_valid ? head[LANES + int'(lane) * W +: W] : '0;
  assign y_idx = y_valid ? {lane[1] ? sel2 : sel1, lane} : '0;
  assign fire = y_valid & y_ready;
  assign pop = fire & y_last;
  assign push = (|valid_in) & (~full | pop);
  assign overflow = ovf_q;

  // EMIT tracks "FIFO holds an entry after this edge", so a capture into an idle drain is visible immediately.
  always_comb begin
    sent_d = ~fire ? sent_q : y_last ? '0 : sent_q | (LANES'(1) << lane);
    state_d = ((count + CW'(push) - CW'(pop)) != '0) ? EMIT : IDLE;
    ovf_d = ((|valid_in) & ~push) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sent_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q <= sent_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter W, default 8, output element width.
REQ-002 SHALL have parameter ACC_W, default 16, accumulator width.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter SHIFT, default 4, requantisation right-shift (0..ACC_W-1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports acc_in_0..acc_in_3  input  ACC_W signed each  MAC array accumulator outputs.
REQ-008 SHALL have port valid_in  input  4  per-lane accumulator valid, bit l for acc_in_l.
REQ-009 SHALL have ports acc_sel_tile1, acc_sel_tile2  input  3 each  row-tile index for lanes 0-1 and 2-3.
REQ-010 SHALL have port y_data  output  W signed  requantised result.
REQ-011 SHALL have port y_idx  output  5  output row index.
REQ-012 SHALL have ports y_valid output 1, y_ready input 1, y_last output 1  result stream handshake; y_last marks final lane of an entry.
REQ-013 SHALL have ports full output 1, empty output 1, overflow output 1 (sticky), clr_ovf input 1.

Function
REQ-014 Capture: on a clk edge with valid_in != 0 and FIFO not full, SHALL write one entry {mask=valid_in, four requantised lanes, sel1, sel2}.
REQ-015 valid_in == 0 SHALL write nothing.
REQ-016 Requant per lane: arithmetic shift acc >>> SHIFT, then saturate to [-2^(W-1), 2^(W-1)-1].
REQ-017 Row index: lane l in {0,1} gives sel1*4+l; lane l in {2,3} gives sel2*4+l.
REQ-018 Latency: valid_in at edge t SHALL give y_valid high after edge t when the FIFO was empty and FSM in IDLE, i.e. earliest transfer at edge t+1.
REQ-019 FSM states IDLE, EMIT; IDLE->EMIT when FIFO non-empty; EMIT->IDLE when the last set lane transfers and the FIFO becomes empty.
REQ-020 In EMIT, lane pointer SHALL select the lowest set mask bit not yet sent; unset lanes skipped with no bubble cycle.
REQ-021 Each y_valid&&y_ready SHALL advance to the next set lane; after the last set lane (y_last=1) pop head and continue on the next entry in the same cycle without a bubble.
REQ-022 y_data, y_idx, y_last SHALL hold stable while y_valid=1 and y_ready=0.
REQ-023 Push while full without a same-edge pop SHALL drop the entry and set overflow; push and pop on the same edge when full SHALL both succeed.
REQ-024 clr_ovf=1 SHALL clear overflow at the next edge; a simultaneous drop SHALL leave overflow set.
REQ-025 full = (count==DEPTH), empty = (count==0); pointers wrap modulo DEPTH.

Reset
REQ-026 rst low SHALL asynchronously force FSM=IDLE, FIFO pointers/count=0, lane pointer=0, y_valid=0, y_data=0, y_idx=0, y_last=0, full=0, empty=1, overflow=0.
REQ-027 Reset mid-EMIT SHALL discard all buffered entries; after release, the first valid_in restarts at an empty FIFO.

Configuration
REQ-028 With RESULT_DRAIN_RELU_EN defined, negative shifted values SHALL be forced to 0 before saturation; without it, signed saturation only.

Structure
REQ-029 Lane count (4), row-index width (5) and the saturate constants SHALL reside in shared package systolic_pkg.
REQ-030 Storage SHALL be one sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-031 Single entry: valid_in=4'b1111, acc=16,-32,4096,-4096, sel1=0, sel2=1, SHIFT=4, y_ready=1 -> y_data 1,-2,127,-128; y_idx 0,1,6,7; y_last on 4th only.
REQ-032 Sparse mask: valid_in=4'b1010, sel1=2 -> exactly two transfers, y_idx 9 then 11, y_last on second, no bubble.
REQ-033 Backpressure: y_ready=0 for 5 cycles mid-entry -> outputs held; 9 pushes with DEPTH=8 -> full=1, 9th dropped, overflow=1; clr_ovf -> overflow=0.
REQ-034 Full push+pop same edge: FIFO full, y_ready=1 on last lane while valid_in!=0 -> no drop, count stays 8, overflow=0.
REQ-035 RELU: acc_in_0=-160 with RESULT_DRAIN_RELU_EN -> y_data 0; without -> -10.
REQ-036 Async reset asserted mid-EMIT between clk edges -> y_valid=0, empty=1 immediately; first post-reset entry emitted correctly.
